interrupt_controller_vectored: RTL
==================================

Name: interrupt_controller_vectored

Overview:
- Multi-source, vectored successor to the single-line PC-redirect interrupt control in the RV32IM pipeline.
- Latches edge-triggered requests from NUM_IRQ sources and applies an enable mask.
- Picks the highest-priority pending source, redirects the PC to that source's vector, and writes the return PC to register RET_REG.
- Sits between the PC-next logic and the PC register, beside the register-file write port.

Parameters:
- NUM_IRQ, 4: number of interrupt sources (1..16); index 0 has the highest priority.
- PC_WIDTH, 32: PC width.
- VECTOR_BASE, 500: ISR address for source 0.
- VECTOR_STRIDE, 16: byte spacing between consecutive source vectors.
- RET_REG, 30: register-file index that holds the return PC; `jalr` through it ends the ISR.
- REG_ADDR_WIDTH, 5: register address width.

Ports:
- clk  in  1  CPU clock; all state updates on the falling edge.
- reset  in  1  reset, synchronous, active-high.
- irq_in  in  NUM_IRQ  raw request lines; a rising edge requests service.
- irq_enable  in  NUM_IRQ  per-source enable mask.
- pc_next  in  PC_WIDTH  PC proposed by the pipeline.
- jalr_select  in  1  current instruction is `jalr`.
- rs1_addr  in  REG_ADDR_WIDTH  `jalr` base register index.
- pc_next_final  out  PC_WIDTH  PC delivered to the PC register.
- pc_save  out  PC_WIDTH  return PC for the register file (equals pc_next).
- save_en  out  1  register-file write enable for RET_REG.
- irq_ack  out  NUM_IRQ  one-hot pulse naming the source being dispatched.
- in_isr  out  1  high while an ISR is executing.
- active_id  out  clog2(NUM_IRQ) (min 1)  index of the source being serviced.

Behaviour:
- Edge detect:
  - irq_prev register, reset to 0.
  - rise = irq_in & ~irq_prev. A line already high when reset is released counts as a rise on the first cycle.
- Pending register (NUM_IRQ bits, reset 0):
  - Set by rise regardless of mask.
  - The dispatched bit is cleared in DISPATCH.
  - Set and clear on the same bit in the same cycle: set wins (request stays pending).
- eligible = pending & irq_enable. Winner = lowest-index set bit.
- States, encoded as 2 bits; unused encoding returns to IDLE:
  - IDLE
    - If eligible != 0: latch winner into active_id, go to DISPATCH. Otherwise stay.
    - Outputs: pc_next_final = pc_next.
  - DISPATCH (exactly one cycle)
    - pc_next_final = VECTOR_BASE + active_id*VECTOR_STRIDE, computed in PC_WIDTH bits (wraps modulo 2^PC_WIDTH).
    - save_en = 1; irq_ack[active_id] = 1; clear pending[active_id]. Then go to ISR.
  - ISR
    - pc_next_final = pc_next; in_isr = 1.
    - If jalr_select && rs1_addr == RET_REG: go to IDLE. Otherwise stay.
- No nesting:
  - Requests arriving during DISPATCH or ISR only accumulate in pending.
  - Mask changes during ISR do not affect active_id.
- Return with another request pending: at least one IDLE cycle, then dispatch the next winner. Back-to-back service takes 2 cycles minimum from return to the next redirect.
- Output decode:
  - save_en, irq_ack, pc_next_final and in_isr are combinational from state.
  - in_isr = 1 in DISPATCH and ISR.
- Reset (including mid-ISR):
  - Next falling edge: state = IDLE, pending = 0, irq_prev = 0, active_id = 0.
  - Outputs then: save_en = 0, irq_ack = 0, in_isr = 0, pc_next_final = pc_next.
- Masked pending bits persist until enabled and serviced; they are never dropped.
- Latency: rise on edge N → DISPATCH during cycle N+1 → redirect takes effect at edge N+2.

Decomposition:
- Shared package (cpu-level interrupt definitions):
  - State encodings IDLE/DISPATCH/ISR.
  - Defaults for VECTOR_BASE, VECTOR_STRIDE, RET_REG.
- Sub-module irq_priority_encoder:
  - Parametrised by NUM_IRQ.
  - Maps eligible to {valid, index}, lowest index wins.
- The existing 32-bit 2:1 PC mux may be reused for the pc_next / vector selection.

Test Plan:
- Single source:
  - Stimulus: NUM_IRQ=4, enable=4'b1111, pulse irq_in[2] in IDLE, pc_next=0x40.
  - Response: one DISPATCH cycle with pc_next_final=532, save_en=1, pc_save=0x40, irq_ack=4'b0100. Then ISR; jalr with rs1=30 → IDLE.
- Priority:
  - Stimulus: rises on irq_in[1] and irq_in[3] in the same cycle.
  - Response: source 1 dispatched first (vector 516). After return, one IDLE cycle, then source 3 (vector 548).
- Masking:
  - Stimulus: enable=4'b1110, rise on irq_in[0].
  - Response: no dispatch and pending[0] stays 1. Setting enable[0]=1 causes dispatch of vector 500 on the following cycle.
- Non-return jalr:
  - Stimulus: in ISR, jalr with rs1=5.
  - Response: stays in ISR, in_isr=1. Only rs1=30 exits.
- No nesting:
  - Stimulus: rise on irq_in[0] during an ISR for source 2.
  - Response: no redirect until return; source 0 dispatched after the mandatory IDLE cycle.
- Reset mid-ISR:
  - Stimulus: assert reset for 1 cycle with pending=4'b1010.
  - Response: IDLE, pending=0, pc_next_final=pc_next. A line held high then produces a fresh dispatch after reset deasserts.

Source files
------------

// File: rtl/interrupt_controller_vectored_pkg.sv
// Shared CPU-level interrupt definitions: controller state encoding and
// default vector/return-register placement.
package interrupt_controller_vectored_pkg;

    // Controller states. 2'b11 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DISPATCH = 2'b01,
        ST_ISR      = 2'b10
    } irq_state_t;

    localparam int DEF_VECTOR_BASE   = 500;
    localparam int DEF_VECTOR_STRIDE = 16;
    localparam int DEF_RET_REG       = 30;

    // Width of a source index; a single source still needs one bit.
    function automatic int irq_id_width(input int num_irq);
        return (num_irq > 1) ? $clog2(num_irq) : 1;
    endfunction

endpackage

// File: rtl/interrupt_controller_vectored_irq_priority_encoder.sv
// Fixed-priority encoder: lowest set index of the eligible vector wins.
module interrupt_controller_vectored_irq_priority_encoder
    import interrupt_controller_vectored_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = irq_id_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] i_eligible,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_index
);

    // Scan from the highest index down so the lowest set bit is written last.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_valid = 1'b1;
                o_index = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller_vectored.sv
// Vectored interrupt controller: latches rising-edge requests, picks the
// highest-priority enabled source, redirects the PC to its vector for one
// cycle while saving the return PC into RET_REG, and waits in the ISR until
// a jalr through RET_REG. All state updates on the falling clock edge.
module interrupt_controller_vectored
    import interrupt_controller_vectored_pkg::*;
#(
    parameter int NUM_IRQ        = 4,
    parameter int PC_WIDTH       = 32,
    parameter int VECTOR_BASE    = DEF_VECTOR_BASE,
    parameter int VECTOR_STRIDE  = DEF_VECTOR_STRIDE,
    parameter int RET_REG        = DEF_RET_REG,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ID_W           = irq_id_width(NUM_IRQ)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_IRQ-1:0]        i_irq_in,
    input  logic [NUM_IRQ-1:0]        i_irq_enable,
    input  logic [PC_WIDTH-1:0]       i_pc_next,
    input  logic                      i_jalr_select,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
    output logic [PC_WIDTH-1:0]       o_pc_next_final,
    output logic [PC_WIDTH-1:0]       o_pc_save,
    output logic                      o_save_en,
    output logic [NUM_IRQ-1:0]        o_irq_ack,
    output logic                      o_in_isr,
    output logic [ID_W-1:0]           o_active_id
);

    localparam logic [PC_WIDTH-1:0]       LP_BASE   = PC_WIDTH'(VECTOR_BASE);
    localparam logic [PC_WIDTH-1:0]       LP_STRIDE = PC_WIDTH'(VECTOR_STRIDE);
    localparam logic [REG_ADDR_WIDTH-1:0] LP_RET    = REG_ADDR_WIDTH'(RET_REG);

    irq_state_t          r_state;
    irq_state_t          w_next_state;
    logic [NUM_IRQ-1:0]  r_irq_prev;
    logic [NUM_IRQ-1:0]  r_pending;
    logic [ID_W-1:0]     r_active_id;

    logic [NUM_IRQ-1:0]  w_rise;
    logic [NUM_IRQ-1:0]  w_eligible;
    logic [NUM_IRQ-1:0]  w_active_onehot;
    logic [NUM_IRQ-1:0]  w_clear;
    logic                w_win_valid;
    logic [ID_W-1:0]     w_win_index;
    logic [PC_WIDTH-1:0] w_vector;
    logic                w_return;

    // irq_prev resets to 0, so a line held high through reset is seen as a rise.
    assign w_rise          = i_irq_in & ~r_irq_prev;
    assign w_eligible      = r_pending & i_irq_enable;
    assign w_active_onehot = NUM_IRQ'(1) << r_active_id;
    // Vector address wraps modulo 2^PC_WIDTH.
    assign w_vector        = LP_BASE + PC_WIDTH'(r_active_id) * LP_STRIDE;
    assign w_return        = i_jalr_select && (i_rs1_addr == LP_RET);
    assign o_pc_save       = i_pc_next;
    assign o_active_id     = r_active_id;

    interrupt_controller_vectored_irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio (
        .i_eligible (w_eligible),
        .o_valid    (w_win_valid),
        .o_index    (w_win_index)
    );

    // State, edge history, pending latch and active source; new rises beat the dispatch clear.
    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_irq_prev  <= '0;
            r_pending   <= '0;
            r_active_id <= '0;
        end else begin
            r_state    <= w_next_state;
            r_irq_prev <= i_irq_in;
            r_pending  <= (r_pending & ~w_clear) | w_rise;
            if (r_state == ST_IDLE && w_win_valid) begin
                r_active_id <= w_win_index;
            end
        end
    end

    // Next-state and output decode; outputs depend only on state (plus pass-through PC).
    always_comb begin
        w_next_state    = r_state;
        o_pc_next_final = i_pc_next;
        o_save_en       = 1'b0;
        o_irq_ack       = '0;
        o_in_isr        = 1'b0;
        w_clear         = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_next_state = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                o_pc_next_final = w_vector;
                o_save_en       = 1'b1;
                o_irq_ack       = w_active_onehot;
                o_in_isr        = 1'b1;
                w_clear         = w_active_onehot;
                w_next_state    = ST_ISR;
            end
            ST_ISR: begin
                o_in_isr = 1'b1;
                if (w_return) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule
